shift_sequencer: RTL and testbench

- Front-end controller for the 16-bit combinational shift stage; sits directly upstream of that stage and consumes its result.
- Accepts shift requests with amounts up to 63 over a valid/ready handshake.
- Splits large arithmetic shifts into successive passes of at most 15 positions through the 4-bit-amount stage.
- Accumulates each pass result in a register and returns the final value on a valid/ready response channel.

---
 rtl/shift_sequencer.sv | 123 ++++++++++++
 tb/tb_shift_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Front-end sequencer for the 16-bit shift stage: splits large arithmetic shifts
// into passes of at most 15 positions and returns the accumulated result.
module shift_sequencer #(
    parameter int AMT_W  = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AMT_W-1:0]  req_amt,
    input  logic              req_lr,
    input  logic              req_rot,
    output logic [DATA_W-1:0] shf_in,
    output logic [3:0]        shf_shift,
    output logic              shf_lr,
    output logic              shf_rot,
    input  logic [DATA_W-1:0] shf_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [2:0]        rsp_passes
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // RUN   | one shift-stage pass per clock until the remaining amount is zero
    // DONE  | result held on the response channel until rsp_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_acc;
    logic [AMT_W-1:0]   r_rem;
    logic               r_dir;
    logic               r_rot;
    logic [2:0]         r_passes;
    logic [3:0]         r_shf_shift;
    logic               r_req_ready;
    logic               r_rsp_valid;

    logic [AMT_W-1:0]   w_rem_load;
    logic [AMT_W-1:0]   w_rem_next;

    function automatic logic [3:0] step_of(input logic [AMT_W-1:0] rem);
        return (rem > AMT_W'(15)) ? 4'd15 : rem[3:0];
    endfunction

    // Rotates wrap at 16, so only the low nibble of the amount matters.
    assign w_rem_load = req_rot ? AMT_W'(req_amt[3:0]) : req_amt;
    assign w_rem_next = r_rem - AMT_W'(r_shf_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_dir       <= 1'b0;
            r_rot       <= 1'b0;
            r_passes    <= '0;
            r_shf_shift <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_acc       <= req_data;
                        r_dir       <= req_lr;
                        r_rot       <= req_rot;
                        r_passes    <= '0;
                        r_rem       <= w_rem_load;
                        r_req_ready <= 1'b0;
                        if (w_rem_load == '0) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_shf_shift <= '0;
                        end else begin
                            r_state     <= RUN;
                            r_shf_shift <= step_of(w_rem_load);
                        end
                    end
                end
                RUN: begin
                    // r_shf_shift already holds this pass's step, precomputed a cycle early.
                    r_acc    <= shf_out;
                    r_rem    <= w_rem_next;
                    r_passes <= r_passes + 3'd1;
                    if (w_rem_next == '0) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_shf_shift <= '0;
                    end else begin
                        r_shf_shift <= step_of(w_rem_next);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_shf_shift <= '0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign shf_in     = r_acc;
    assign shf_shift  = r_shf_shift;
    assign shf_lr     = r_dir;
    assign shf_rot    = r_rot;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_acc;
    assign rsp_passes = r_passes;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the shift stage.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [5:0]  req_amt;
    logic        req_lr;
    logic        req_rot;
    logic [15:0] shf_in;
    logic [3:0]  shf_shift;
    logic        shf_lr;
    logic        shf_rot;
    logic [15:0] shf_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_passes;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.AMT_W(6), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_lr     (req_lr),
        .req_rot    (req_rot),
        .shf_in     (shf_in),
        .shf_shift  (shf_shift),
        .shf_lr     (shf_lr),
        .shf_rot    (shf_rot),
        .shf_out    (shf_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_passes (rsp_passes)
    );

    // Shift stage: logical left, arithmetic right, or rotate by 0..15.
    always_comb begin
        shf_out = shf_in;
        if (shf_rot) begin
            if (shf_lr) shf_out = (shf_in << shf_shift) | (shf_in >> (16 - int'(shf_shift)));
            else        shf_out = (shf_in >> shf_shift) | (shf_in << (16 - int'(shf_shift)));
        end else begin
            if (shf_lr) shf_out = shf_in << shf_shift;
            else        shf_out = 16'($signed(shf_in) >>> shf_shift);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // seq holds the expected per-pass shf_shift values, pass 0 in the low nibble.
    task automatic run_req(input string tag, input logic [15:0] d, input logic [5:0] a,
                           input logic lr, input logic rot, input logic [15:0] exp_d,
                           input logic [2:0] exp_p, input int exp_n, input logic [19:0] seq);
        int n;
        req_data  = d;
        req_amt   = a;
        req_lr    = lr;
        req_rot   = rot;
        req_valid = 1'b1;
        check_val({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 8) begin
            if (n < 5) check_val({tag, "_shift"}, 32'(shf_shift), 32'(seq[n*4 +: 4]));
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_latency"}, 32'(n), 32'(exp_n));
        check_val({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check_val({tag, "_passes"}, 32'(rsp_passes), 32'(exp_p));
        check_val({tag, "_shift_done"}, 32'(shf_shift), 32'd0);
        check_val({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_val({tag, "_ready_post"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        req_lr    = 1'b0;
        req_rot   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd1);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_val("rst_rsp_passes", 32'(rsp_passes), 32'd0);
        check_val("rst_shf_shift", 32'(shf_shift), 32'd0);
        check_val("rst_shf_in", 32'(shf_in), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("shl4",   16'h0003, 6'd4,  1'b1, 1'b0, 16'h0030, 3'd1, 1, 20'h00004);
        run_req("sar20",  16'h8000, 6'd20, 1'b0, 1'b0, 16'hFFFF, 3'd2, 2, 20'h0005F);
        run_req("shl63",  16'hFFFF, 6'd63, 1'b1, 1'b0, 16'h0000, 3'd5, 5, 20'h3FFFF);
        run_req("ror19",  16'h0001, 6'd19, 1'b0, 1'b1, 16'h2000, 3'd1, 1, 20'h00003);
        run_req("rot32",  16'hA5A5, 6'd32, 1'b1, 1'b1, 16'hA5A5, 3'd0, 0, 20'h00000);
        run_req("amt0",   16'h1234, 6'd0,  1'b1, 1'b0, 16'h1234, 3'd0, 0, 20'h00000);

        // Backpressure: hold the response while hammering req_valid.
        req_data  = 16'h0003;
        req_amt   = 6'd4;
        req_lr    = 1'b1;
        req_rot   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_val("bp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_data  = 16'hFFFF;
            req_amt   = 6'd1;
            check_val("bp_data", 32'(rsp_data), 32'h30);
            check_val("bp_passes", 32'(rsp_passes), 32'd1);
            check_val("bp_ready", 32'(req_ready), 32'd0);
            check_val("bp_hold_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("bp_release_valid", 32'(rsp_valid), 32'd0);
        check_val("bp_release_ready", 32'(req_ready), 32'd1);
        check_val("bp_acc_kept", 32'(rsp_data), 32'h30);
        @(posedge clk); #1;
        check_val("bp_idle_ready", 32'(req_ready), 32'd1);

        // Reset during the second RUN cycle of a 40-position shift.
        req_data  = 16'h4000;
        req_amt   = 6'd40;
        req_lr    = 1'b0;
        req_rot   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("rst_run1_shift", 32'(shf_shift), 32'd15);
        @(posedge clk); #1;
        check_val("rst_run2_shift", 32'(shf_shift), 32'd15);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_mid_ready", 32'(req_ready), 32'd1);
        check_val("rst_mid_shift", 32'(shf_shift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("rst_after_valid", 32'(rsp_valid), 32'd0);
            check_val("rst_after_ready", 32'(req_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
